mtr_drv: RTL and testbench

Motor drive stage directly downstream of `balance_cntrl`. It turns the 11-bit `lft_spd`/`rght_spd` magnitudes and the `lft_rev`/`rght_rev` direction flags into forward/reverse PWM pairs for the two H-bridges. A shared 2048-clock PWM counter drives both channels. Each channel captures its duty and direction only at period boundaries, and inserts a dead interval on every direction reversal so the forward and reverse legs are never driven back-to-back.

---
 rtl/segway_pkg.sv | 14 +
 rtl/mtr_chan.sv | 74 +++++++
 rtl/mtr_drv.sv | 60 ++++++
 tb/tb_mtr_drv.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared definitions for the motor drive stage: PWM width, period end value
// and the per-channel drive state.
package segway_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] PWM_MAX = 11'h7FF;

    // RUN drives the selected leg from the duty compare; DEAD holds both legs low
    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chan_state_t;

endpackage

// File: rtl/mtr_chan.sv
// One H-bridge channel: captures duty/direction at period boundaries, runs
// the RUN/DEAD state machine and registers the forward/reverse leg drives.
module mtr_chan
    import segway_pkg::*;
#(
    parameter int DEAD_CYC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] cnt,
    input  logic             bnd,
    input  logic [PWM_W-1:0] spd,
    input  logic             rev,
    output logic             pwm_frwrd,
    output logic             pwm_rev
);

    // Last dead-counter value before returning to RUN
    localparam logic [PWM_W-1:0] DEAD_LAST = PWM_W'(DEAD_CYC - 1);

    logic [PWM_W-1:0] duty_q;
    logic             rev_cap;
    logic             rev_act;
    chan_state_t      state;
    logic [PWM_W-1:0] dcnt;
    logic             pwm;

    // Raw PWM: unsigned compare against the captured duty, gated off in DEAD
    assign pwm = (cnt < duty_q) && (state == RUN);

    // Duty and requested direction are sampled only on the period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q  <= '0;
            rev_cap <= 1'b0;
        end else if (bnd) begin
            duty_q  <= spd;
            rev_cap <= rev;
        end
    end

    // Direction FSM with dead interval, plus registered leg drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            dcnt      <= '0;
            rev_act   <= 1'b0;
            pwm_frwrd <= 1'b0;
            pwm_rev   <= 1'b0;
        end else begin
            // rev_act only changes while DEAD forces pwm low, so the legs
            // can never both be high
            pwm_frwrd <= pwm && !rev_act;
            pwm_rev   <= pwm && rev_act;
            case (state)
                RUN: begin
                    if (bnd && (rev != rev_act)) begin
                        state <= DEAD;
                        dcnt  <= '0;
                    end
                end
                DEAD: begin
                    dcnt <= dcnt + PWM_W'(1);
                    if (dcnt == DEAD_LAST) begin
                        state   <= RUN;
                        rev_act <= rev_cap;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Motor drive top: one free-running PWM counter shared by the left and right
// H-bridge channels, with a boundary strobe at the end of each period.
module mtr_drv
    import segway_pkg::*;
#(
    parameter int DEAD_CYC = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] lft_spd,
    input  logic             lft_rev,
    input  logic [PWM_W-1:0] rght_spd,
    input  logic             rght_rev,
    output logic             PWM_frwrd_lft,
    output logic             PWM_rev_lft,
    output logic             PWM_frwrd_rght,
    output logic             PWM_rev_rght
);

    logic [PWM_W-1:0] cnt;
    logic             bnd;

    // Free-running period counter, wraps naturally at PWM_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_W'(1);
        end
    end

    assign bnd = (cnt == PWM_MAX);

    mtr_chan #(
        .DEAD_CYC (DEAD_CYC)
    ) u_lft (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .bnd       (bnd),
        .spd       (lft_spd),
        .rev       (lft_rev),
        .pwm_frwrd (PWM_frwrd_lft),
        .pwm_rev   (PWM_rev_lft)
    );

    mtr_chan #(
        .DEAD_CYC (DEAD_CYC)
    ) u_rght (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .bnd       (bnd),
        .spd       (rght_spd),
        .rev       (rght_rev),
        .pwm_frwrd (PWM_frwrd_rght),
        .pwm_rev   (PWM_rev_rght)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-period reference model checked every clock, a table
// of steady-state duty/direction rows, hand-written reversal and reset
// sequences, and randomized input changes.
module tb_mtr_drv;

    localparam int DEAD = 32;
    localparam int PER  = 2048;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lft_spd;
    logic        lft_rev;
    logic [10:0] rght_spd;
    logic        rght_rev;
    logic        PWM_frwrd_lft;
    logic        PWM_rev_lft;
    logic        PWM_frwrd_rght;
    logic        PWM_rev_rght;

    int checks   = 0;
    int failures = 0;

    mtr_drv #(
        .DEAD_CYC (DEAD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lft_spd        (lft_spd),
        .lft_rev        (lft_rev),
        .rght_spd       (rght_spd),
        .rght_rev       (rght_rev),
        .PWM_frwrd_lft  (PWM_frwrd_lft),
        .PWM_rev_lft    (PWM_rev_lft),
        .PWM_frwrd_rght (PWM_frwrd_rght),
        .PWM_rev_rght   (PWM_rev_rght)
    );

    always #5 clk = ~clk;

    // Reference model: a per-period "plan" per channel (index 0 = left,
    // 1 = right). Position k within the period is the counter value seen on
    // the edge; the plan in force for a period is fixed at its boundary.
    int mcnt;
    int pd[2];
    bit pdir[2];
    bit pdead[2];
    bit act[2];
    bit ef[2];
    bit er[2];
    int hf[2];
    int hr[2];

    task automatic model_reset();
        mcnt = 0;
        for (int c = 0; c < 2; c++) begin
            pd[c]    = 0;
            pdir[c]  = 1'b0;
            pdead[c] = 1'b0;
            act[c]   = 1'b0;
        end
    endtask

    task automatic clear_hits();
        for (int c = 0; c < 2; c++) begin
            hf[c] = 0;
            hr[c] = 0;
        end
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock: predict on the rising edge, compare on the falling edge
    task automatic step();
        int spd_in[2];
        bit rev_in[2];
        bit hi;
        @(posedge clk);
        spd_in[0] = int'(lft_spd);
        spd_in[1] = int'(rght_spd);
        rev_in[0] = lft_rev;
        rev_in[1] = rght_rev;
        for (int c = 0; c < 2; c++) begin
            hi    = (mcnt < pd[c]) && !(pdead[c] && (mcnt < DEAD));
            ef[c] = hi && !pdir[c];
            er[c] = hi && pdir[c];
        end
        if (mcnt == PER - 1) begin
            for (int c = 0; c < 2; c++) begin
                pd[c]    = spd_in[c];
                pdead[c] = (rev_in[c] != act[c]);
                pdir[c]  = rev_in[c];
                act[c]   = rev_in[c];
            end
        end
        mcnt = (mcnt + 1) % PER;
        @(negedge clk);
        checks++;
        if ({PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght} !== {ef[0], er[0], ef[1], er[1]}
            || dut.cnt !== 11'(mcnt)) begin
            failures++;
            $display("FAIL cycle t=%0t outs=%b exp=%b cnt=%0d exp_cnt=%0d", $time,
                     {PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght},
                     {ef[0], er[0], ef[1], er[1]}, dut.cnt, mcnt);
        end
        checks++;
        if ((PWM_frwrd_lft && PWM_rev_lft) || (PWM_frwrd_rght && PWM_rev_rght)) begin
            failures++;
            $display("FAIL both_legs t=%0t outs=%b exp=no pair high", $time,
                     {PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght});
        end
        hf[0] += int'(PWM_frwrd_lft);
        hr[0] += int'(PWM_rev_lft);
        hf[1] += int'(PWM_frwrd_rght);
        hr[1] += int'(PWM_rev_rght);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance through the next boundary edge (at most one period)
    task automatic to_boundary();
        do step(); while (mcnt != 0);
    endtask

    // Count leg-high clocks over one full period starting at k = 0
    task automatic measure();
        clear_hits();
        run(PER);
    endtask

    task automatic check_outs_zero(input string name);
        check_eq(name, int'({PWM_frwrd_lft, PWM_rev_lft, PWM_frwrd_rght, PWM_rev_rght}), 0);
    endtask

    typedef struct {
        logic [10:0] ls;
        logic        lr;
        logic [10:0] rs;
        logic        rr;
        int          lf;
        int          lrv;
        int          rf;
        int          rrv;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2ms;
        $display("FAIL timeout t=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Rows applied in order; expected counts are for the first full
        // period after the row's inputs are captured (reversal costs DEAD).
        tbl[0] = '{11'h400, 1'b0, 11'h000, 1'b0, 1024,    0,    0,    0};
        tbl[1] = '{11'h400, 1'b0, 11'h7FF, 1'b0, 1024,    0, 2047,    0};
        tbl[2] = '{11'h100, 1'b1, 11'h7FF, 1'b0,    0,  224, 2047,    0};
        tbl[3] = '{11'h100, 1'b1, 11'h000, 1'b0,    0,  256,    0,    0};
        tbl[4] = '{11'h010, 1'b0, 11'h005, 1'b1,    0,    0,    0,    0};
        tbl[5] = '{11'h7FF, 1'b0, 11'h7FF, 1'b1, 2047,    0,    0, 2047};
        tbl[6] = '{11'h000, 1'b1, 11'h020, 1'b0,    0,    0,    0,    0};
        tbl[7] = '{11'h021, 1'b1, 11'h021, 1'b0,    0,   33,   33,    0};

        rst_n    = 1'b0;
        lft_spd  = '0;
        lft_rev  = 1'b0;
        rght_spd = '0;
        rght_rev = 1'b0;
        model_reset();
        clear_hits();
        #1;
        check_outs_zero("reset_outs");
        check_eq("reset_cnt", int'(dut.cnt), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle: two periods with zero inputs, counter wraps
        run(2 * PER);
        $display("idle 4096 clocks done");

        // Table rows
        for (int r = 0; r < 8; r++) begin
            lft_spd  = tbl[r].ls;
            lft_rev  = tbl[r].lr;
            rght_spd = tbl[r].rs;
            rght_rev = tbl[r].rr;
            to_boundary();
            measure();
            check_eq($sformatf("row%0d_lf", r), hf[0], tbl[r].lf);
            check_eq($sformatf("row%0d_lr", r), hr[0], tbl[r].lrv);
            check_eq($sformatf("row%0d_rf", r), hf[1], tbl[r].rf);
            check_eq($sformatf("row%0d_rr", r), hr[1], tbl[r].rrv);
            $display("row %0d lft=%h/%0d rght=%h/%0d counts lf=%0d lr=%0d rf=%0d rr=%0d",
                     r, tbl[r].ls, tbl[r].lr, tbl[r].rs, tbl[r].rr, hf[0], hr[0], hf[1], hr[1]);
        end

        // Mid-period reversal, then changes inside DEAD
        lft_spd  = 11'h100;
        lft_rev  = 1'b0;
        rght_spd = 11'h300;
        rght_rev = 1'b1;
        to_boundary();
        to_boundary();
        clear_hits();
        run(1000);
        lft_rev = 1'b1;
        run(PER - 1000);
        check_eq("rev_tail_lf", hf[0], 256);
        check_eq("rev_tail_lr", hr[0], 0);
        clear_hits();
        run(10);
        lft_spd = 11'h050;
        lft_rev = 1'b0;
        run(10);
        lft_rev = 1'b1;
        run(PER - 20);
        check_eq("rev_dead_lf", hf[0], 0);
        check_eq("rev_dead_lr", hr[0], 224);
        check_eq("rev_dead_rr", hr[1], 768);
        check_eq("rev_dead_rf", hf[1], 0);
        measure();
        check_eq("rev_next_lr", hr[0], 80);
        check_eq("rev_next_rr", hr[1], 768);
        $display("reversal sequence lr=%0d rr=%0d", hr[0], hr[1]);

        // Reset while left is in DEAD and right is driving
        lft_spd  = 11'h100;
        lft_rev  = 1'b0;
        rght_spd = 11'h7FF;
        rght_rev = 1'b0;
        to_boundary();
        to_boundary();
        lft_rev = 1'b1;
        to_boundary();
        run(10);
        check_eq("pre_reset_rf", int'(PWM_frwrd_rght), 1);
        #2 rst_n = 1'b0;
        #1;
        check_outs_zero("async_reset_outs");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs_zero("held_reset_outs");
        end
        #2 rst_n = 1'b1;
        model_reset();
        to_boundary();
        measure();
        check_eq("post_reset_lr", hr[0], 224);
        check_eq("post_reset_lf", hf[0], 0);
        check_eq("post_reset_rf", hf[1], 2047);
        $display("reset sequence lr=%0d rf=%0d", hr[0], hf[1]);

        // Randomized input changes at arbitrary points in the period
        for (int i = 0; i < 8; i++) begin
            lft_spd  = 11'($urandom_range(0, 2047));
            lft_rev  = 1'($urandom_range(0, 1));
            rght_spd = 11'($urandom_range(0, 2047));
            rght_rev = 1'($urandom_range(0, 1));
            run($urandom_range(1, 2000));
            $display("random %0d lft=%h/%0d rght=%h/%0d", i, lft_spd, lft_rev, rght_spd, rght_rev);
        end
        run(PER + 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
